// File: rtl/fetch_control.sv
// Instruction decode and program-counter sequencing: decode is combinational, and the PC takes the next address one clk after the instruction is presented.
// There is no backpressure: a new instruction is accepted on every clock edge.
module fetch_control #(
    parameter int D   = 10,
    parameter int OPW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   mach_code,
    input  logic [7:0]   datA,
    input  logic [7:0]   datB,
    input  logic [7:0]   mem_out,
    input  logic [7:0]   mem_lut_out,
    input  logic [7:0]   alu_rslt,
    output logic [D-1:0] prog_ctr,
    output logic [3:0]   regA,
    output logic [3:0]   regB,
    output logic [3:0]   wr_addr,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         MemtoReg,
    output logic         ALUSrc,
    output logic         Branch,
    output logic [3:0]   ALUOp,
    output logic [7:0]   dat_in,
    output logic [7:0]   mem_in,
    output logic [7:0]   mem_addr,
    output logic [4:0]   immed,
    output logic [3:0]   pc_immed
);

    localparam logic [OPW-1:0] OP_MOVA = OPW'(4'b1000);
    localparam logic [OPW-1:0] OP_MOVR = OPW'(4'b1001);
    localparam logic [OPW-1:0] OP_LDM  = OPW'(4'b1010);
    localparam logic [OPW-1:0] OP_STM  = OPW'(4'b1011);
    localparam logic [OPW-1:0] OP_LDR  = OPW'(4'b1100);
    localparam logic [OPW-1:0] OP_STR  = OPW'(4'b1101);
    localparam logic [OPW-1:0] OP_BZ   = OPW'(4'b1110);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(4'b1111);

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    logic [OPW-1:0] op;
    logic [3:0]     n;
    logic [D-1:0]   jump_lut [16];
    logic [D-1:0]   target;

    assign op       = mach_code[8:9-OPW];
    assign n        = mach_code[3:0];
    assign immed    = mach_code[4:0];
    assign pc_immed = mach_code[3:0];

    // Jump targets sit on 16-instruction boundaries.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            jump_lut[k] = D'(16 * k);
        end
    end

    assign target = jump_lut[pc_immed];

    always_comb begin
        regA     = 4'd0;
        regB     = n;
        wr_addr  = 4'd0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        ALUOp    = op[OPW-1] ? 4'd0 : 4'(op);
        mem_in   = datA;
        mem_addr = 8'd0;
        dat_in   = alu_rslt;

        if (!op[OPW-1]) begin
            // ALU group: result always lands in the accumulator R0.
            RegWrite = 1'b1;
            ALUSrc   = mach_code[4];
        end else begin
            case (op)
                OP_MOVA: begin
                    RegWrite = 1'b1;
                    dat_in   = datB;
                end
                OP_MOVR: begin
                    RegWrite = 1'b1;
                    wr_addr  = n;
                    dat_in   = datA;
                end
                OP_LDM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    mem_addr = mem_lut_out;
                    dat_in   = mem_out;
                end
                OP_STM: begin
                    MemWrite = 1'b1;
                    mem_addr = mem_lut_out;
                end
                OP_LDR: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    mem_addr = datB;
                    dat_in   = mem_out;
                end
                OP_STR: begin
                    MemWrite = 1'b1;
                    mem_addr = datB;
                end
                OP_BZ: begin
                    Branch = (datA == 8'd0);
                end
                OP_JMP: begin
                    // bit 4 selects BNZ; clear means unconditional jump.
                    Branch = mach_code[4] ? (datA != 8'd0) : 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prog_ctr <= '0;
        end else if (Branch) begin
            prog_ctr <= target;
        end else begin
            prog_ctr <= prog_ctr + PC_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: expected decode and next PC are queued on drive and compared on output.
module tb_fetch_control;

    localparam int D = 10;

    logic         clk;
    logic         reset;
    logic [8:0]   mach_code;
    logic [7:0]   datA, datB, mem_out, mem_lut_out, alu_rslt;
    logic [D-1:0] prog_ctr;
    logic [3:0]   regA, regB, wr_addr;
    logic         RegWrite, MemWrite, MemtoReg, ALUSrc, Branch;
    logic [3:0]   ALUOp;
    logic [7:0]   dat_in, mem_in, mem_addr;
    logic [4:0]   immed;
    logic [3:0]   pc_immed;

    typedef struct packed {
        logic [3:0] regA;
        logic [3:0] regB;
        logic [3:0] wr_addr;
        logic       RegWrite;
        logic       MemWrite;
        logic       MemtoReg;
        logic       ALUSrc;
        logic       Branch;
        logic [3:0] ALUOp;
        logic [7:0] dat_in;
        logic [7:0] mem_in;
        logic [7:0] mem_addr;
        logic [4:0] immed;
        logic [3:0] pc_immed;
    } ctrl_t;

    ctrl_t        ctrl_q [$];
    logic [D-1:0] pc_q [$];
    logic [D-1:0] model_pc;
    int           checks = 0;
    int           errors = 0;

    fetch_control #(.D(D), .OPW(4)) dut (
        .clk(clk), .reset(reset), .mach_code(mach_code),
        .datA(datA), .datB(datB), .mem_out(mem_out),
        .mem_lut_out(mem_lut_out), .alu_rslt(alu_rslt),
        .prog_ctr(prog_ctr), .regA(regA), .regB(regB), .wr_addr(wr_addr),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .Branch(Branch), .ALUOp(ALUOp),
        .dat_in(dat_in), .mem_in(mem_in), .mem_addr(mem_addr),
        .immed(immed), .pc_immed(pc_immed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t model(input logic [8:0] mc, input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] mo, input logic [7:0] ml, input logic [7:0] ar);
        ctrl_t      c;
        logic [3:0] op;
        op = mc[8:5];
        c = '0;
        c.regB     = mc[3:0];
        c.ALUOp    = (op < 4'd8) ? op : 4'd0;
        c.mem_in   = a;
        c.dat_in   = ar;
        c.immed    = mc[4:0];
        c.pc_immed = mc[3:0];
        if (op < 4'd8) begin
            c.RegWrite = 1'b1;
            c.ALUSrc   = mc[4];
        end
        case (op)
            4'd8:  begin c.RegWrite = 1'b1; c.dat_in = b; end
            4'd9:  begin c.RegWrite = 1'b1; c.wr_addr = mc[3:0]; c.dat_in = a; end
            4'd10: begin c.RegWrite = 1'b1; c.MemtoReg = 1'b1; c.mem_addr = ml; c.dat_in = mo; end
            4'd11: begin c.MemWrite = 1'b1; c.mem_addr = ml; end
            4'd12: begin c.RegWrite = 1'b1; c.MemtoReg = 1'b1; c.mem_addr = b; c.dat_in = mo; end
            4'd13: begin c.MemWrite = 1'b1; c.mem_addr = b; end
            4'd14: c.Branch = (a == 8'd0);
            4'd15: c.Branch = mc[4] ? (a != 8'd0) : 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Drive one instruction, queue expectations, then compare decode and the PC after the edge.
    task automatic step(input logic [8:0] mc, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] mo, input logic [7:0] ml, input logic [7:0] ar);
        ctrl_t        e, o;
        logic [D-1:0] ep;
        mach_code = mc; datA = a; datB = b; mem_out = mo; mem_lut_out = ml; alu_rslt = ar;
        e = model(mc, a, b, mo, ml, ar);
        ctrl_q.push_back(e);
        model_pc = e.Branch ? D'(32'(mc[3:0]) * 16) : D'(model_pc + 1);
        pc_q.push_back(model_pc);
        #1;
        o = {regA, regB, wr_addr, RegWrite, MemWrite, MemtoReg, ALUSrc, Branch,
             ALUOp, dat_in, mem_in, mem_addr, immed, pc_immed};
        if (ctrl_q.size() == 0) check_val("decode_q_empty", 64'd1, 64'd0);
        else check_val("decode", 64'(o), 64'(ctrl_q.pop_front()));
        @(posedge clk);
        #1;
        if (pc_q.size() == 0) check_val("pc_q_empty", 64'd1, 64'd0);
        else check_val("pc", 64'(prog_ctr), 64'(pc_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic nop();
        step(9'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mach_code = 9'b0; datA = 0; datB = 0; mem_out = 0; mem_lut_out = 0; alu_rslt = 0;
        model_pc = '0;
        repeat (2) @(negedge clk);
        check_val("reset_pc", 64'(prog_ctr), 64'd0);
        reset = 1'b0;

        // Count up to 37, then reset asynchronously between edges.
        repeat (37) nop();
        check_val("pc_at_37", 64'(prog_ctr), 64'd37);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_reset", 64'(prog_ctr), 64'd0);
        @(posedge clk);
        #1;
        check_val("reset_held", 64'(prog_ctr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_pc = '0;
        repeat (3) nop();
        check_val("after_reset_3", 64'(prog_ctr), 64'd3);

        // JMP 5 from pc 7, then self-loop.
        repeat (4) nop();
        check_val("pc_at_7", 64'(prog_ctr), 64'd7);
        step(9'b1111_0_0101, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("jmp_branch", 64'(Branch), 64'd1);
        check_val("jmp_target", 64'(prog_ctr), 64'd80);
        step(9'b1111_0_0101, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("self_loop", 64'(prog_ctr), 64'd80);

        // BZ taken and not taken.
        step(9'b1110_0_0010, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("bz_taken", 64'(prog_ctr), 64'd32);
        step(9'b1110_0_0010, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("bz_not_branch", 64'(Branch), 64'd0);
        check_val("bz_not_taken", 64'(prog_ctr), 64'd33);

        // BNZ taken and not taken.
        step(9'b1111_1_0011, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("bnz_taken", 64'(prog_ctr), 64'd48);
        step(9'b1111_1_0011, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("bnz_not_taken", 64'(prog_ctr), 64'd49);

        // ALU immediate decode.
        step(9'b0011_1_0110, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A);
        check_val("alu_op", 64'(ALUOp), 64'h3);
        check_val("alu_src", 64'(ALUSrc), 64'd1);
        check_val("alu_regwrite", 64'(RegWrite), 64'd1);
        check_val("alu_wr_addr", 64'(wr_addr), 64'd0);
        check_val("alu_immed", 64'(immed), 64'b10110);
        check_val("alu_dat_in", 64'(dat_in), 64'h5A);

        // STR and LDM.
        step(9'b1101_0_0100, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00);
        check_val("str_memwrite", 64'(MemWrite), 64'd1);
        check_val("str_mem_addr", 64'(mem_addr), 64'h3C);
        check_val("str_mem_in", 64'(mem_in), 64'hA5);
        check_val("str_regwrite", 64'(RegWrite), 64'd0);
        step(9'b1010_0_0011, 8'h00, 8'h00, 8'h77, 8'h40, 8'h99);
        check_val("ldm_mem_addr", 64'(mem_addr), 64'h40);
        check_val("ldm_dat_in", 64'(dat_in), 64'h77);
        check_val("ldm_memtoreg", 64'(MemtoReg), 64'd1);

        // MOVR writes Rn with R0.
        step(9'b1001_0_0110, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("movr_wr_addr", 64'(wr_addr), 64'd6);
        check_val("movr_dat_in", 64'(dat_in), 64'hC3);

        // Random instruction mix through the scoreboard.
        for (int i = 0; i < 60; i++) begin
            step(9'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Walk up to 1023 and wrap.
        step(9'b1111_0_1111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("jmp_240", 64'(prog_ctr), 64'd240);
        repeat (783) nop();
        check_val("pc_at_1023", 64'(prog_ctr), 64'd1023);
        nop();
        check_val("pc_wrap", 64'(prog_ctr), 64'd0);

        check_val("queues_drained", 64'(ctrl_q.size() + pc_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
